nexus_work_scheduler: RTL and testbench
=======================================

# nexus_work_scheduler

Sequences a bank of `HASHERS` SK1024 hash cores that share one work packet and one active-low core reset, each core stepping its nonce by `HASHERS`. The scheduler accepts jobs from the host, loads them into the cores, bounds each job to a fixed nonce range, and drains the pipeline. It collects and range-checks per-core good-nonce reports, then arbitrates them into a result FIFO toward the miner interface.

## Interface
- `HASHERS`, 4, number of cores; must be a power of two.
- `PIPE_LATENCY`, 390, core pipeline depth in cycles: 2 Skein blocks × 122, plus 3 Keccak blocks × 48, plus 2.
- `RANGE_BITS`, 32, log2 of the nonces each core hashes per job.
- `FIFO_DEPTH`, 8, result FIFO entries; must be a power of two.
- `clk`  in  1  sole clock.
- `nRst`  in  1  asynchronous active-low reset.
- `work_valid`  in  1  job offered.
- `work_ready`  out  1  job accepted when high together with `work_valid`.
- `work_pkt`  in  1728  header tail [639:0] plus midstate [1727:640].
- `work_nonce`  in  64  base nonce of the job.
- `work_id`  in  8  job tag.
- `core_nHashRst`  out  1  shared active-low core reload/park.
- `core_work_pkt`  out  1728  registered copy of the accepted `work_pkt`.
- `core_nonce`  out  64  registered base nonce.
- `core_good`  in  HASHERS  per-core good-nonce strobe.
- `core_nonce_out`  in  64·HASHERS  per-core reported nonce; core i occupies [64i+:64].
- `res_valid` / `res_ready`  out / in  1  result handshake.
- `res_nonce`  out  64  result nonce.
- `res_id`  out  8  job tag of the result.
- `busy`  out  1  high when the state is not IDLE.
- `job_done`  out  1  one-cycle pulse when DRAIN completes.
- `res_overflow`  out  1  sticky; set when any result is dropped; cleared only by reset.

## Operation
- States: IDLE → LOAD → RUN → DRAIN → IDLE.
- IDLE: `core_nHashRst`=0, which parks the cores. `work_ready`=1.
- Accepting a job in IDLE latches `work_pkt`, `work_nonce` and `work_id`, then moves to LOAD.
- LOAD: lasts exactly 1 cycle with `core_nHashRst`=0, then moves to RUN.
- RUN: `core_nHashRst`=1. A counter of `RANGE_BITS`+1 bits counts RUN cycles. After 2^RANGE_BITS RUN cycles the state moves to DRAIN.
- DRAIN: `core_nHashRst`=1 for exactly `PIPE_LATENCY` cycles. The block then pulses `job_done` and returns to IDLE.
- Preemption: `work_ready`=1 in RUN and DRAIN as well. A new accept in either state relatches the job and goes to LOAD. No `job_done` is issued for the preempted job.
- Result acceptance: a report from core i is taken only when all of the following hold:
  - state is RUN or DRAIN;
  - `core_good[i]`=1;
  - (nonce − base), computed modulo 2^64, is below `HASHERS`·2^RANGE_BITS.
  - Out-of-range reports are discarded silently.
- Per-core holding register: each accepted report is stored with its nonce and the current `work_id`. If a core's register is still occupied when a new report arrives, the new report is dropped and `res_overflow` is set.
- A round-robin arbiter moves one held entry per cycle into the FIFO while the FIFO is not full. The pointer advances to the index after the winner.
- LOAD clears all holding registers; the FIFO is untouched.
- Reset: state=IDLE, `core_nHashRst`=0, `work_ready`=0 during reset and 1 from the first cycle after release. All other outputs are 0, and the FIFO and holding registers are empty.

## Timing
- Accept to the first cycle of `core_nHashRst`=1: 2 cycles (the LOAD cycle, then RUN).
- Job length from LOAD entry to the `job_done` pulse: 1 + 2^RANGE_BITS + `PIPE_LATENCY` cycles.
- `core_good` to `res_valid`, with an empty FIFO and no contention: 3 cycles (hold, FIFO write, FIFO output register).
- FIFO: a full FIFO back-pressures the arbiter only; it never stalls the cores. A simultaneous push and pop on a full FIFO is allowed.
- `res_valid` is held until `res_ready`. `res_nonce` and `res_id` stay stable while `res_valid`=1 and `res_ready`=0.
- The range check wraps modulo 2^64, so a base near 2^64−1 is handled correctly.

## Structure
- Package `nexus_pkg` holds:
  - `WORK_PKT_W`=1728;
  - `NONCE_W`=64;
  - `PIPE_LATENCY`=390;
  - the state enum `sched_state_t`;
  - the result struct {nonce, id}.
- Sub-module `nexus_result_fifo`: synchronous FIFO, parameterised by depth and width, with a registered output.

## Test plan
- `HASHERS`=4, `RANGE_BITS`=4, `PIPE_LATENCY`=10, job accepted at cycle 0 → LOAD at cycle 1, RUN for cycles 2–17, DRAIN for cycles 18–27, `job_done` at cycle 28.
- Base=100, core 2 reports nonce 130 → `res_nonce`=130 with the correct `res_id` 3 cycles later. A report of nonce 164 (offset 64, out of range) and a report of nonce 99 (below base) are both dropped, and `res_overflow` stays 0.
- All four cores strobe in the same cycle → four results emerge in round-robin order 0, 1, 2, 3 on consecutive cycles.
- `res_ready` held at 0 and 12 reports arrive → FIFO holds 8, each core then holds 1, further reports set `res_overflow`, and `core_nHashRst` remains 1 throughout.
- New job accepted mid-RUN → LOAD follows immediately, a stale report after LOAD carrying the old nonce range is rejected, and no `job_done` is issued for the preempted job.
- `nRst` asserted mid-DRAIN → all outputs go to reset values asynchronously, the FIFO is empty, and `core_nHashRst`=0.

Source files
------------

// File: rtl/nexus_pkg.sv
// Shared types and constants for the SK1024 work scheduler and its result path.
package nexus_pkg;

  localparam int WORK_PKT_W   = 1728;
  localparam int NONCE_W      = 64;
  localparam int PIPE_LATENCY = 390;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [NONCE_W-1:0] nonce;
    logic [7:0]         id;
  } result_t;

  localparam int RESULT_W = $bits(result_t);

endpackage

// File: rtl/nexus_work_scheduler_fifo.sv
// Result FIFO: array storage plus a registered output stage; occupancy counts both.
module nexus_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 72
) (
  input  logic             clk,
  input  logic             nRst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      mem_cnt_q;
  logic [AW:0]      mem_cnt_d;
  logic [AW+1:0]    total;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             pop;
  logic             load;
  logic             wr;

  assign pop        = out_valid_q && out_ready_i;
  assign total      = {1'b0, mem_cnt_q} + {{(AW+1){1'b0}}, out_valid_q};
  // A pop in the same cycle frees a slot, so a full FIFO still takes a push.
  assign in_ready_o = (total != (AW+2)'(DEPTH)) || pop;
  assign wr         = push_i && in_ready_o;
  assign load       = (mem_cnt_q != '0) && (!out_valid_q || pop);
  assign mem_cnt_d  = mem_cnt_q + (AW+1)'(wr) - (AW+1)'(load);

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      mem_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      mem_cnt_q <= mem_cnt_d;
      if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        out_data_q <= mem_q[rd_ptr_q];
      end
      if (load)     out_valid_q <= 1'b1;
      else if (pop) out_valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/nexus_work_scheduler.sv
// Job sequencer for a bank of SK1024 cores: load/run/drain control, range-checked
// result capture, round-robin arbitration into the result FIFO.
module nexus_work_scheduler
  import nexus_pkg::*;
#(
  parameter int HASHERS      = 4,
  parameter int PIPE_LATENCY = nexus_pkg::PIPE_LATENCY,
  parameter int RANGE_BITS   = 32,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                        clk,
  input  logic                        nRst,
  input  logic                        work_valid,
  output logic                        work_ready,
  input  logic [WORK_PKT_W-1:0]       work_pkt,
  input  logic [NONCE_W-1:0]          work_nonce,
  input  logic [7:0]                  work_id,
  output logic                        core_nHashRst,
  output logic [WORK_PKT_W-1:0]       core_work_pkt,
  output logic [NONCE_W-1:0]          core_nonce,
  input  logic [HASHERS-1:0]          core_good,
  input  logic [NONCE_W*HASHERS-1:0]  core_nonce_out,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [NONCE_W-1:0]          res_nonce,
  output logic [7:0]                  res_id,
  output logic                        busy,
  output logic                        job_done,
  output logic                        res_overflow
);

  localparam int HW = $clog2(HASHERS);
  localparam int DW = $clog2(PIPE_LATENCY + 1);
  localparam logic [NONCE_W-1:0] RANGE_LIMIT = NONCE_W'(HASHERS) << RANGE_BITS;

  sched_state_t state_q, state_d;
  logic [RANGE_BITS:0] run_cnt_q, run_cnt_d;
  logic [DW-1:0]       drain_cnt_q, drain_cnt_d;
  logic                ready_en_q;
  logic                job_done_q, job_done_d;
  logic                accept, run_last, drain_last;

  logic [WORK_PKT_W-1:0] pkt_q;
  logic [NONCE_W-1:0]    base_q;
  logic [7:0]            id_q;
  logic                  ovf_q;

  logic [HASHERS-1:0] hold_valid, take, drop, grant;
  result_t            hold_data [HASHERS];
  logic [HW-1:0]      rr_q, rr_d, win_idx;
  logic               win_found, arb_push, fifo_in_ready;
  logic [RESULT_W-1:0] fifo_out_bits;
  result_t            fifo_out;

  assign accept     = work_valid && work_ready;
  assign run_last   = run_cnt_q == {1'b0, {RANGE_BITS{1'b1}}};
  assign drain_last = drain_cnt_q == DW'(PIPE_LATENCY - 1);
  assign job_done_d = (state_q == DRAIN) && drain_last && !accept;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q     <= IDLE;
      run_cnt_q   <= '0;
      drain_cnt_q <= '0;
      ready_en_q  <= 1'b0;
      job_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      ready_en_q  <= 1'b1;
      job_done_q  <= job_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    run_cnt_d   = '0;
    drain_cnt_d = '0;
    unique case (state_q)
      IDLE:  if (accept) state_d = LOAD;
      LOAD:  state_d = RUN;
      RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        if (accept)        state_d = LOAD;
        else if (run_last) state_d = DRAIN;
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (accept)          state_d = LOAD;
        else if (drain_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    core_nHashRst = 1'b0;
    busy          = 1'b1;
    work_ready    = ready_en_q;
    unique case (state_q)
      IDLE:    busy = 1'b0;
      LOAD:    work_ready = 1'b0;
      RUN:     core_nHashRst = 1'b1;
      DRAIN:   core_nHashRst = 1'b1;
      default: busy = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      pkt_q  <= '0;
      base_q <= '0;
      id_q   <= '0;
      ovf_q  <= 1'b0;
      rr_q   <= '0;
    end else begin
      if (accept) begin
        pkt_q  <= work_pkt;
        base_q <= work_nonce;
        id_q   <= work_id;
      end
      if (|drop) ovf_q <= 1'b1;
      rr_q <= rr_d;
    end
  end

  for (genvar gi = 0; gi < HASHERS; gi++) begin : g_core
    logic [NONCE_W-1:0] nonce_in;
    logic [NONCE_W-1:0] offset;
    logic               report_ok;
    logic               valid_q;
    result_t            entry_q;

    assign nonce_in  = core_nonce_out[gi*NONCE_W +: NONCE_W];
    // Modulo-2^64 difference makes reports below the base wrap to huge offsets.
    assign offset    = nonce_in - base_q;
    assign report_ok = core_nHashRst && core_good[gi] && (offset < RANGE_LIMIT);
    assign take[gi]  = report_ok && !valid_q;
    assign drop[gi]  = report_ok && valid_q;

    assign hold_valid[gi] = valid_q;
    assign hold_data[gi]  = entry_q;

    always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
        valid_q <= 1'b0;
        entry_q <= '0;
      end else if (state_q == LOAD) begin
        valid_q <= 1'b0;
      end else if (take[gi]) begin
        valid_q       <= 1'b1;
        entry_q.nonce <= nonce_in;
        entry_q.id    <= id_q;
      end else if (grant[gi]) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Scan downward so the lowest offset from the pointer is the last (winning) hit.
  always_comb begin
    win_found = 1'b0;
    win_idx   = rr_q;
    for (int k = HASHERS - 1; k >= 0; k--) begin
      if (hold_valid[rr_q + HW'(k)]) begin
        win_found = 1'b1;
        win_idx   = rr_q + HW'(k);
      end
    end
    arb_push = win_found && fifo_in_ready && (state_q != LOAD);
    grant    = '0;
    rr_d     = rr_q;
    if (arb_push) begin
      grant[win_idx] = 1'b1;
      rr_d           = win_idx + HW'(1);
    end
  end

  nexus_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RESULT_W)
  ) u_fifo (
    .clk         (clk),
    .nRst        (nRst),
    .push_i      (arb_push),
    .data_i      (hold_data[win_idx]),
    .in_ready_o  (fifo_in_ready),
    .out_valid_o (res_valid),
    .out_data_o  (fifo_out_bits),
    .out_ready_i (res_ready)
  );

  assign fifo_out      = result_t'(fifo_out_bits);
  assign res_nonce     = fifo_out.nonce;
  assign res_id        = fifo_out.id;
  assign core_work_pkt = pkt_q;
  assign core_nonce    = base_q;
  assign job_done      = job_done_q;
  assign res_overflow  = ovf_q;

endmodule

// File: tb/tb_nexus_work_scheduler.sv
// Directed bench for nexus_work_scheduler with a short job (4 cores, 16 RUN cycles, 10 DRAIN).
module tb_nexus_work_scheduler;
  import nexus_pkg::*;

  localparam int H  = 4;
  localparam int RB = 4;
  localparam int PL = 10;
  localparam int FD = 8;

  logic                  clk = 1'b0;
  logic                  nRst = 1'b0;
  logic                  work_valid;
  logic                  work_ready;
  logic [WORK_PKT_W-1:0] work_pkt;
  logic [63:0]           work_nonce;
  logic [7:0]            work_id;
  logic                  core_nHashRst;
  logic [WORK_PKT_W-1:0] core_work_pkt;
  logic [63:0]           core_nonce;
  logic [H-1:0]          core_good;
  logic [64*H-1:0]       core_nonce_out;
  logic                  res_valid;
  logic                  res_ready;
  logic [63:0]           res_nonce;
  logic [7:0]            res_id;
  logic                  busy;
  logic                  job_done;
  logic                  res_overflow;

  always #5 clk = ~clk;

  nexus_work_scheduler #(
    .HASHERS(H), .PIPE_LATENCY(PL), .RANGE_BITS(RB), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .nRst(nRst),
    .work_valid(work_valid), .work_ready(work_ready), .work_pkt(work_pkt),
    .work_nonce(work_nonce), .work_id(work_id),
    .core_nHashRst(core_nHashRst), .core_work_pkt(core_work_pkt), .core_nonce(core_nonce),
    .core_good(core_good), .core_nonce_out(core_nonce_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_nonce(res_nonce), .res_id(res_id),
    .busy(busy), .job_done(job_done), .res_overflow(res_overflow)
  );

  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;
  int cyc = 0;
  int jd_cnt = 0;
  int k;
  logic [WORK_PKT_W-1:0] pkt_a, pkt_b, pkt_c, pkt_d;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
    cyc++;
    if (job_done) jd_cnt++;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) next();
  endtask

  task automatic offer(input logic [63:0] base, input logic [7:0] id, input logic [WORK_PKT_W-1:0] pkt);
    work_valid = 1'b1;
    work_nonce = base;
    work_id    = id;
    work_pkt   = pkt;
    check("offer_ready", 64'(work_ready), 64'd1);
    next();
    work_valid = 1'b0;
  endtask

  task automatic strobe(input logic [3:0] mask, input logic [63:0] n0, input logic [63:0] n1,
                        input logic [63:0] n2, input logic [63:0] n3);
    core_good = mask;
    core_nonce_out = {n3, n2, n1, n0};
    next();
    core_good = '0;
  endtask

  initial begin
    work_valid = 1'b0; work_pkt = '0; work_nonce = '0; work_id = '0;
    core_good = '0; core_nonce_out = '0; res_ready = 1'b0;
    pkt_a = {27{64'h0123_4567_89AB_CDEF}};
    pkt_b = {27{64'hA5A5_0000_1111_2222}};
    pkt_c = {27{64'h5555_AAAA_5555_AAAA}};
    pkt_d = {27{64'hDEAD_BEEF_0BAD_F00D}};

    // Reset values
    @(negedge clk);
    check("rst_ready", 64'(work_ready), 64'd0);
    check("rst_nhashrst", 64'(core_nHashRst), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_ovf", 64'(res_overflow), 64'd0);
    check("rst_job_done", 64'(job_done), 64'd0);
    nRst = 1'b1;
    next();
    check("ready_after_rst", 64'(work_ready), 64'd1);

    // Job A: timing, single result, range rejection, round robin
    cyc = 0; jd_cnt = 0;
    offer(64'd100, 8'h3C, pkt_a);
    check("A_load_nhr", 64'(core_nHashRst), 64'd0);
    check("A_load_busy", 64'(busy), 64'd1);
    check("A_load_ready", 64'(work_ready), 64'd0);
    check("A_core_nonce", core_nonce, 64'd100);
    check("A_core_pkt", 64'(core_work_pkt === pkt_a), 64'd1);
    next();
    check("A_run_nhr", 64'(core_nHashRst), 64'd1);
    next();
    strobe(4'b0100, 64'd0, 64'd0, 64'd130, 64'd0);
    strobe(4'b0010, 64'd0, 64'd164, 64'd0, 64'd0);
    check("A_lat_c5", 64'(res_valid), 64'd0);
    strobe(4'b1000, 64'd0, 64'd0, 64'd0, 64'd99);
    check("A_lat_c6_valid", 64'(res_valid), 64'd1);
    check("A_nonce130", res_nonce, 64'd130);
    check("A_id", 64'(res_id), 64'h3C);
    res_ready = 1'b1;
    next();
    res_ready = 1'b0;
    check("A_drop164", 64'(res_valid), 64'd0);
    next();
    check("A_drop99", 64'(res_valid), 64'd0);
    check("A_no_ovf", 64'(res_overflow), 64'd0);
    strobe(4'b1000, 64'd0, 64'd0, 64'd0, 64'd163);
    next();
    check("A_edge_c10", 64'(res_valid), 64'd0);
    next();
    check("A_edge_valid", 64'(res_valid), 64'd1);
    check("A_edge_nonce", res_nonce, 64'd163);
    res_ready = 1'b1;
    next();
    strobe(4'b1111, 64'd101, 64'd102, 64'd103, 64'd104);
    next();
    check("A_rr_c14", 64'(res_valid), 64'd0);
    next();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("A_rr%0d_valid", i), 64'(res_valid), 64'd1);
      check($sformatf("A_rr%0d_nonce", i), res_nonce, 64'(101 + i));
      next();
    end
    check("A_rr_empty", 64'(res_valid), 64'd0);
    res_ready = 1'b0;
    run_to(27);
    check("A_c27_done", 64'(job_done), 64'd0);
    check("A_c27_nhr", 64'(core_nHashRst), 64'd1);
    next();
    check("A_done_pulse", 64'(job_done), 64'd1);
    check("A_done_idle", 64'(busy), 64'd0);
    check("A_done_nhr", 64'(core_nHashRst), 64'd0);
    check("A_done_count", 64'(jd_cnt), 64'd1);
    next();
    check("A_done_once", 64'(job_done), 64'd0);

    // Job B: FIFO fill, per-core holds, overflow
    cyc = 0; jd_cnt = 0;
    offer(64'd1000, 8'h55, pkt_b);
    next();
    strobe(4'b1111, 64'd1000, 64'd1001, 64'd1002, 64'd1003);
    run_to(7);
    strobe(4'b1111, 64'd1004, 64'd1005, 64'd1006, 64'd1007);
    run_to(12);
    strobe(4'b1111, 64'd1008, 64'd1009, 64'd1010, 64'd1011);
    check("B_head_valid", 64'(res_valid), 64'd1);
    check("B_head_nonce", res_nonce, 64'd1000);
    next();
    check("B_ovf_before", 64'(res_overflow), 64'd0);
    strobe(4'b1111, 64'd1012, 64'd1013, 64'd1014, 64'd1015);
    check("B_ovf_set", 64'(res_overflow), 64'd1);
    check("B_nhr_kept", 64'(core_nHashRst), 64'd1);
    check("B_head_stable", res_nonce, 64'd1000);
    res_ready = 1'b1;
    k = 0;
    for (int g = 0; g < 40 && k < 12; g++) begin
      if (res_valid) begin
        check($sformatf("B_res%0d_nonce", k), res_nonce, 64'(1000 + k));
        check($sformatf("B_res%0d_id", k), 64'(res_id), 64'h55);
        k++;
      end
      next();
    end
    check("B_res_count", 64'(k), 64'd12);
    check("B_no_extra", 64'(res_valid), 64'd0);
    res_ready = 1'b0;
    run_to(32);
    check("B_idle", 64'(busy), 64'd0);

    // Job C preempted by job D
    cyc = 0; jd_cnt = 0;
    offer(64'd5000, 8'h11, pkt_c);
    run_to(5);
    offer(64'd9000, 8'h22, pkt_d);
    check("D_load_nhr", 64'(core_nHashRst), 64'd0);
    check("D_load_busy", 64'(busy), 64'd1);
    check("D_core_nonce", core_nonce, 64'd9000);
    check("D_core_pkt", 64'(core_work_pkt === pkt_d), 64'd1);
    next();
    strobe(4'b0010, 64'd0, 64'd5010, 64'd0, 64'd0);
    strobe(4'b0001, 64'd9005, 64'd0, 64'd0, 64'd0);
    next();
    check("D_stale_dropped", 64'(res_valid), 64'd0);
    next();
    check("D_res_valid", 64'(res_valid), 64'd1);
    check("D_res_nonce", res_nonce, 64'd9005);
    check("D_res_id", 64'(res_id), 64'h22);
    res_ready = 1'b1;
    next();
    res_ready = 1'b0;
    run_to(32);
    check("C_no_done", 64'(jd_cnt), 64'd0);
    check("ovf_sticky", 64'(res_overflow), 64'd1);
    next();
    check("D_done_pulse", 64'(job_done), 64'd1);
    next();

    // Job E: wrap-around base, then asynchronous reset mid-DRAIN
    cyc = 0; jd_cnt = 0;
    offer(64'hFFFF_FFFF_FFFF_FFF0, 8'h77, pkt_a);
    run_to(3);
    strobe(4'b0100, 64'd0, 64'd0, 64'h20, 64'd0);
    strobe(4'b0010, 64'd0, 64'h40, 64'd0, 64'd0);
    next();
    check("E_wrap_valid", 64'(res_valid), 64'd1);
    check("E_wrap_nonce", res_nonce, 64'h20);
    check("E_wrap_id", 64'(res_id), 64'h77);
    res_ready = 1'b1;
    next();
    res_ready = 1'b0;
    check("E_wrap_reject", 64'(res_valid), 64'd0);
    run_to(15);
    strobe(4'b0001, 64'h5, 64'd0, 64'd0, 64'd0);
    run_to(20);
    check("E_pre_valid", 64'(res_valid), 64'd1);
    check("E_pre_nonce", res_nonce, 64'h5);
    check("E_pre_nhr", 64'(core_nHashRst), 64'd1);
    #2 nRst = 1'b0;
    #1;
    check("E_arst_valid", 64'(res_valid), 64'd0);
    check("E_arst_nonce", res_nonce, 64'd0);
    check("E_arst_id", 64'(res_id), 64'd0);
    check("E_arst_nhr", 64'(core_nHashRst), 64'd0);
    check("E_arst_busy", 64'(busy), 64'd0);
    check("E_arst_ready", 64'(work_ready), 64'd0);
    check("E_arst_ovf", 64'(res_overflow), 64'd0);
    check("E_arst_core_nonce", core_nonce, 64'd0);
    check("E_arst_done", 64'(job_done), 64'd0);
    next();
    check("E_in_rst_ready", 64'(work_ready), 64'd0);
    nRst = 1'b1;
    next();
    check("E_rel_ready", 64'(work_ready), 64'd1);
    check("E_rel_nhr", 64'(core_nHashRst), 64'd0);
    next();
    next();
    check("E_fifo_empty", 64'(res_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
